// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage types and constants (FSM states, NOP word, reset PC, opcodes, opcode helper)
package if_stage_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [5:0] OP_HALT = 6'h3F;
  function automatic logic [5:0] opcode(input logic [31:0] w);
    return w[31:26];
  endfunction
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID register; clk/reset(active-low sync), load captures instr+next_addr as valid, bubble clears, else hold
module if_id_reg import if_stage_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] next_addr,
  output logic [31:0] instruction,
  output logic [31:0] next_address,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      instruction  <= NOP_INSTR;
      next_address <= 32'h0;
      valid        <= 1'b0;
    end else if (load) begin
      instruction  <= instr;
      next_address <= next_addr;
      valid        <= 1'b1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, next-PC mux and BOOT/RUN/HALT FSM feeding IF/ID; in: clk, reset(active-low sync), instr_mem_data, stall, branch/jump + targets; out: instr_mem_addr, IF/ID word/next/fields/valid, halted
module if_stage import if_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_mem_addr,
  input  logic [31:0] instr_mem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] supposed_next_address_if_id,
  output logic [31:0] instruction_if_id,
  output logic [4:0]  next_instruction_20_16_if_id,
  output logic [4:0]  next_instruction_15_11_if_id,
  output logic        valid_if_id,
  output logic        halted
);
  state_t state, state_n;
  logic [31:0] pc, pc_n, target, pc_plus4;
  logic redirect, is_halt, load, bubble;
  always_comb begin
    redirect = branch_taken || jump;
    target   = branch_taken ? branch_target : jump_target;
    pc_plus4 = pc + 32'd4;
    is_halt  = opcode(instr_mem_data) == HALT_OPCODE;
    pc_n     = (state != BOOT && redirect) ? target :
               (state == RUN && !stall && !is_halt) ? pc_plus4 : pc;
    state_n  = state == BOOT ? RUN :
               state == RUN  ? ((!redirect && !stall && is_halt) ? HALT : RUN) :
               (redirect ? RUN : HALT);
    bubble   = state != RUN || redirect || (!stall && is_halt);
    load     = state == RUN && !redirect && !stall && !is_halt;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end
  assign instr_mem_addr               = pc;
  assign halted                       = state == HALT;
  assign next_instruction_20_16_if_id = instruction_if_id[20:16];
  assign next_instruction_15_11_if_id = instruction_if_id[15:11];
  if_id_reg u_if_id (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .bubble       (bubble),
    .instr        (instr_mem_data),
    .next_addr    (pc_plus4),
    .instruction  (instruction_if_id),
    .next_address (supposed_next_address_if_id),
    .valid        (valid_if_id)
  );
endmodule
